// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_pkg
//  Purpose  : Shared register-file constants for the writeback arbiter and
//             its neighbours (address width, register count, x0, sources).
//  Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Writes to x0 are accepted but never reach the register file.
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  // Writeback source indices as wired at the top level.
  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_MISC = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter_if
//  Purpose  : Flattened valid/ready writeback request bus, one slice per
//             requester. master = writeback sources, slave = arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REQ   = 3
);
  import rf_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd;
  logic [NUM_REQ*WORD_SIZE-1:0]  req_data;

  modport master (output req_valid, output req_rd, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rd, input req_data, output req_ready);
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Generic combinational round-robin grant. Searches upward from
//             ptr (wrapping modulo NUM_REQ) and grants the first request.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // One spare bit so ptr + offset never overflows before the wrap.
  logic [SRC_W:0] cand;

  // Walk the candidates in priority order, keeping the first hit.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NUM_REQ)) begin
        cand = cand - (SRC_W+1)'(NUM_REQ);
      end
      if (!grant_valid && req[cand[SRC_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
    grant[grant_idx] = grant_valid;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Purpose  : Shares the register file write port among NUM_REQ writeback
//             sources. Round-robin grant, one-cycle registered write, and a
//             pending-destination mask for hazard logic.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter  int WORD_SIZE = 16,
  parameter  int NUM_REQ   = 3,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,        // asynchronous, active low
  input  logic                    wb_stall,
  regfile_write_arbiter_if.slave  req,
  output logic                    rf_en,
  output logic [REG_ADDR_W-1:0]   rf_rd,
  output logic [WORD_SIZE-1:0]    rf_data,
  output logic [SRC_W-1:0]        rf_src,
  output logic [NUM_REGS-1:0]     pending_mask
);

  logic [SRC_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [SRC_W-1:0]     win_idx;
  logic                 win_valid;
  reg_addr_t            win_rd;
  logic [WORD_SIZE-1:0] win_data;

  // A stall hides every request from the arbiter, so nothing is granted.
  assign eligible = wb_stall ? '0 : req.req_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (eligible),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (win_idx),
    .grant_valid (win_valid)
  );

  // Grants are suppressed while reset is held so no transfer can be lost.
  assign req.req_ready = rst ? grant : '0;

  assign win_rd   = req.req_rd[int'(win_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign win_data = req.req_data[int'(win_idx)*WORD_SIZE +: WORD_SIZE];

  // Capture the winner's write and advance the pointer past it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_en   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
      rf_src  <= '0;
      ptr     <= '0;
    end else begin
      // x0 writes are consumed but never enabled at the register file.
      rf_en <= win_valid && (win_rd != REG_X0);
      if (win_valid) begin
        rf_rd   <= win_rd;
        rf_data <= win_data;
        rf_src  <= win_idx;
        ptr     <= (win_idx == SRC_W'(NUM_REQ-1)) ? '0 : win_idx + SRC_W'(1);
      end
    end
  end

  // rf_en already excludes x0; the bit-0 clear keeps that explicit.
  assign pending_mask = rf_en ? ((NUM_REGS'(1) << rf_rd) & ~(NUM_REGS'(1))) : '0;

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, CSR/misc), using round-robin arbitration with a valid/ready handshake.
- The winner's write is registered and driven onto the register file write port (en/rd/data) one cycle later.
- Exports a pending-destination mask so hazard logic can see the register currently being written.
- Sits between the execute/memory stages and the register file.

Parameters:
- WORD_SIZE, 16, data width; matches the register file.
- NUM_REQ, 3, number of writeback requesters; legal range 2..8.
- SRC_W, $clog2(NUM_REQ), width of the source index. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid&ready.
- req_rd  in  NUM_REQ*5  flattened destination indices; requester i uses bits [5i+4:5i].
- req_data  in  NUM_REQ*WORD_SIZE  flattened write data; requester i uses slice i.
- wb_stall  in  1  blocks all grants this cycle.
- rf_en  out  1  register file write enable.
- rf_rd  out  5  register file destination.
- rf_data  out  WORD_SIZE  register file write data.
- rf_src  out  SRC_W  index of the requester that owns the current rf_* write.
- pending_mask  out  32  one-hot of rf_rd when rf_en=1, else all zero.

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_en=0, rf_rd=0, rf_data=0, rf_src=0.
  - Round-robin pointer=0.
  - req_ready=0 while in reset.
- Grant (combinational, same cycle):
  - If wb_stall=1, all req_ready=0.
  - Otherwise exactly one req_ready bit is set: the first valid requester found searching upward from the pointer, wrapping modulo NUM_REQ.
  - If no requester is valid, req_ready=0.
  - req_ready never depends on req_rd or req_data.
- Handshake rules:
  - A requester holds valid, rd and data stable until it is granted. Retracting valid before grant is illegal; the bench flags it.
  - At most one transfer happens per cycle.
- Latency: exactly one cycle. A grant in cycle N gives rf_en=1 in cycle N+1, with rf_rd, rf_data and rf_src taken from the granted slice. The register file writes on the N+1→N+2 edge.
- Idle or stalled cycle: the next cycle has rf_en=0. rf_rd, rf_data and rf_src hold their previous values (don't-care).
- Destination x0:
  - The request is granted normally and the pointer advances.
  - The next cycle has rf_en=0 and pending_mask=0.
  - rf_rd=0 and rf_src are updated.
- Pointer update:
  - On a transfer by requester i, pointer becomes (i+1) mod NUM_REQ, including wrap from NUM_REQ-1 to 0.
  - With no transfer, the pointer is unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ unstalled cycles.
- Same rd from two requesters in one cycle: only the winner transfers. The loser transfers in a later cycle, so later-granted data wins in the register file. Ordering between sources is the issuer's responsibility.
- pending_mask is combinational from the registered rf_en/rf_rd. Bit 0 is always 0.
- Reset mid-operation: the registered write is discarded (rf_en drops immediately, asynchronously). The pointer returns to 0 and requesters must re-present their requests.

Decomposition:
- Shared package (rf_pkg):
  - REG_ADDR_W=5.
  - NUM_REGS=32.
  - Localparam for the x0 index.
  - Source-index constants (SRC_ALU=0, SRC_LOAD=1, SRC_MISC=2).
- Sub-module rr_arbiter, a generic round-robin grant with a NUM_REQ-wide request vector, pointer input and one-hot grant. It is reusable by later read-port or memory arbiters.
- This block adds the stall gating, the output register, the pointer register and the mask decode.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release with no valid → rf_en=0, pending_mask=0, req_ready=0 every cycle.
- Single write:
  - Stimulus: req_valid=3'b010, rd=7, data=16'hBEEF in cycle N.
  - Required: req_ready=3'b010 in cycle N.
  - Required: cycle N+1 has rf_en=1, rf_rd=7, rf_data=16'hBEEF, rf_src=1, pending_mask=32'h80.
  - Required: the pointer becomes 2.
- Round-robin:
  - Stimulus: all three requesters valid continuously from reset.
  - Required: grant order is 0,1,2,0,1,2 and rf_src follows one cycle later.
  - Required: each transferred requester then presents a new rd/data.
- Stall:
  - Stimulus: valid=3'b101 with wb_stall=1 for 2 cycles.
  - Required: req_ready=0 and no rf_en in either cycle.
  - Required: after stall drops, the grant goes to 0, then 2 (pointer unchanged during the stall).
- x0 and conflict:
  - Stimulus: requester 0 rd=0 and requester 1 rd=5 valid together.
  - Required: cycle 1 grants req 0; the next cycle has rf_en=0 and pending_mask=0.
  - Required: cycle 2 grants req 1; the next cycle has rf_en=1 with rf_rd=5.
- Async reset mid-write:
  - Stimulus: assert rst=0 mid-cycle while rf_en=1.
  - Required: rf_en falls immediately, without waiting for a clock edge.
  - Required: after release, the first grant goes to requester 0.
